// File: rtl/alu_tmr_pkg.sv
// alu_tmr_pkg: shared types and the bitwise majority helper for the ALU TMR voter.
// Contents: tmr_lane_e lane index, tmr_log_entry_t error-log entry, majority3().
package alu_tmr_pkg;

    localparam int TMR_CNT_WIDTH = 16;
    localparam int TMR_TUPLE_W   = 34;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        L3   = 2'd3
    } tmr_lane_e;

    typedef struct packed {
        logic [2:0]               mask;
        logic [TMR_CNT_WIDTH-1:0] stamp;
    } tmr_log_entry_t;

    function automatic logic [TMR_TUPLE_W-1:0] majority3(
        input logic [TMR_TUPLE_W-1:0] a,
        input logic [TMR_TUPLE_W-1:0] b,
        input logic [TMR_TUPLE_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/alu_tmr_err_fifo.sv
// alu_tmr_err_fifo: synchronous FIFO with empty flag and sticky drop-on-full overflow.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync flush), push_i/data_i,
//        pop_i, data_o (head, zero when empty), empty_o, overflow_o.
module alu_tmr_err_fifo #(
    parameter int DW    = 19,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          empty_o,
    output logic          overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q;
    logic          full, do_push, do_pop;

    assign empty_o    = cnt_q == '0;
    assign full       = cnt_q == (AW+1)'(DEPTH);
    // A pop frees the slot a simultaneous push needs, so full+pop+push succeeds.
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full || do_pop);
    assign data_o     = empty_o ? '0 : mem_q[rd_q];
    assign overflow_o = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push_i && !do_push) ovf_q <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_tmr_voter.sv
// alu_tmr_voter: bitwise-majority voter over three ALU observation lanes with error
// classification, saturating error counter, sticky fatal flag and time-stamped log.
// Ports: clk_i, rst_ni (async, active-low), en_i, clear_i, three lanes of
//        alu_result/alu_cmp_result/alu_ready; voted_* outputs, mismatch_o,
//        faulty_lane_o, fatal_o, err_cnt_o; log_rd_i pop, log_valid_o, log_mask_o,
//        log_stamp_o, log_overflow_o.
module alu_tmr_voter import alu_tmr_pkg::*; #(
    parameter int CNT_WIDTH = 16,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clear_i,
    input  logic [31:0]          alu_result_zoix1_i,
    input  logic [31:0]          alu_result_zoix2_i,
    input  logic [31:0]          alu_result_zoix3_i,
    input  logic                 alu_cmp_result_zoix1_i,
    input  logic                 alu_cmp_result_zoix2_i,
    input  logic                 alu_cmp_result_zoix3_i,
    input  logic                 alu_ready_zoix1_i,
    input  logic                 alu_ready_zoix2_i,
    input  logic                 alu_ready_zoix3_i,
    output logic [31:0]          voted_result_o,
    output logic                 voted_cmp_result_o,
    output logic                 voted_ready_o,
    output logic                 mismatch_o,
    output logic [1:0]           faulty_lane_o,
    output logic                 fatal_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    input  logic                 log_rd_i,
    output logic                 log_valid_o,
    output logic [2:0]           log_mask_o,
    output logic [CNT_WIDTH-1:0] log_stamp_o,
    output logic                 log_overflow_o
);

    logic [TMR_TUPLE_W-1:0] lane1, lane2, lane3, vote;
    logic [2:0]             mask;
    tmr_lane_e              lane_sel;
    logic                   hit, multi;

    logic [TMR_TUPLE_W-1:0] voted_q;
    logic                   mismatch_q, mismatch_d;
    logic [1:0]             faulty_q, faulty_d;
    logic                   fatal_q, fatal_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   stamp_q;
    logic [CNT_WIDTH+2:0]   log_head;
    logic                   log_empty;

    assign lane1 = {alu_result_zoix1_i, alu_cmp_result_zoix1_i, alu_ready_zoix1_i};
    assign lane2 = {alu_result_zoix2_i, alu_cmp_result_zoix2_i, alu_ready_zoix2_i};
    assign lane3 = {alu_result_zoix3_i, alu_cmp_result_zoix3_i, alu_ready_zoix3_i};

    always_comb begin
        vote       = majority3(lane1, lane2, lane3);
        mask       = en_i ? {lane3 != vote, lane2 != vote, lane1 != vote} : 3'b000;
        lane_sel   = mask == 3'b001 ? L1 : mask == 3'b010 ? L2 : mask == 3'b100 ? L3 : NONE;
        multi      = (mask != 3'b000) && (lane_sel == NONE);
        // Clear wins: a mismatch in the clearing cycle leaves no trace at all.
        hit        = (mask != 3'b000) && !clear_i;
        mismatch_d = hit;
        faulty_d   = hit ? lane_sel : NONE;
        fatal_d    = !clear_i && (fatal_q || (hit && multi));
        cnt_d      = clear_i ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            voted_q    <= '0;
            mismatch_q <= 1'b0;
            faulty_q   <= '0;
            fatal_q    <= 1'b0;
            cnt_q      <= '0;
            stamp_q    <= '0;
        end else begin
            voted_q    <= vote;
            mismatch_q <= mismatch_d;
            faulty_q   <= faulty_d;
            fatal_q    <= fatal_d;
            cnt_q      <= cnt_d;
            stamp_q    <= stamp_q + 1'b1;
        end
    end

    alu_tmr_err_fifo #(
        .DW    (CNT_WIDTH + 3),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .push_i     (hit),
        .data_i     ({mask, stamp_q}),
        .pop_i      (log_rd_i),
        .data_o     (log_head),
        .empty_o    (log_empty),
        .overflow_o (log_overflow_o)
    );

    assign voted_result_o     = voted_q[33:2];
    assign voted_cmp_result_o = voted_q[1];
    assign voted_ready_o      = voted_q[0];
    assign mismatch_o         = mismatch_q;
    assign faulty_lane_o      = faulty_q;
    assign fatal_o            = fatal_q;
    assign err_cnt_o          = cnt_q;
    assign log_valid_o        = !log_empty;
    assign log_mask_o         = log_head[CNT_WIDTH+2:CNT_WIDTH];
    assign log_stamp_o        = log_head[CNT_WIDTH-1:0];

endmodule

// File: doc/alu_tmr_voter.md
# alu_tmr_voter

Consumes the three redundant ALU observation lanes that `cv32e40p_top` exports (`alu_result_zoix1..3`, `alu_cmp_result_zoix1..3`, `alu_ready_zoix1..3`). It produces a registered bitwise-majority result and classifies every disagreement as single-lane (correctable) or multi-lane (fatal). It keeps a saturating error counter, sticky status and a small time-stamped error log that the bench or a peripheral reads out. It sits next to the core inside the testbench subsystem and closes the otherwise unterminated fault-observation ports.

## Interface
- `CNT_WIDTH`, 16, width of error counter and free-running cycle stamp
- `LOG_DEPTH`, 4, error-log entries; power of two, ≥2
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `en_i` in 1: compare/vote enable; when low, no errors are recorded
- `clear_i` in 1: synchronous clear of counter, sticky flags and log
- `alu_result_zoix1/2/3_i` in 32 each: lane results
- `alu_cmp_result_zoix1/2/3_i` in 1 each: lane compare results
- `alu_ready_zoix1/2/3_i` in 1 each: lane ready
- `voted_result_o` out 32: majority result
- `voted_cmp_result_o` out 1: majority compare result
- `voted_ready_o` out 1: majority ready
- `mismatch_o` out 1: one-cycle pulse, any lane disagreed
- `faulty_lane_o` out 2: 0 = none/multiple, 1..3 = single offending lane (valid with `mismatch_o`)
- `fatal_o` out 1: sticky, a multi-lane disagreement occurred
- `err_cnt_o` out CNT_WIDTH: saturating count of mismatch cycles
- `log_rd_i` in 1: pop request
- `log_valid_o` out 1: log non-empty
- `log_mask_o` out 3: head entry, disagreeing-lane mask (bit0 = lane 1)
- `log_stamp_o` out CNT_WIDTH: head entry cycle stamp
- `log_overflow_o` out 1: sticky, an entry was dropped

## Operation
- Vote: each bit of the 34-bit tuple {result, cmp, ready} is the majority of the three lanes. The vote is computed every cycle, regardless of `en_i`.
- Lane k disagrees when its tuple differs from the voted tuple in any bit. mask = 3-bit disagree vector, qualified by `en_i`.
- popcount(mask)=1: single. `faulty_lane_o` is the lane index, `fatal_o` is unchanged.
- popcount(mask)≥2: multi. This can happen when lanes fail in different bits. `faulty_lane_o`=0 and `fatal_o` is set.
- Any mask≠0:
  - `mismatch_o` pulses.
  - `err_cnt_o` increments and saturates at all-ones.
  - An entry {mask, stamp} is pushed to the log.
- Stamp: free-running CNT_WIDTH counter; it wraps modulo 2^CNT_WIDTH and is not cleared by `clear_i`.
- Log is a FIFO; the head is shown when `log_valid_o`=1.
  - Pop when empty: ignored.
  - Push when full with no pop: entry dropped, `log_overflow_o` set.
  - Push and pop in the same cycle when full: both succeed, occupancy unchanged.
- `clear_i` has priority over a mismatch in the same cycle. The mismatch is discarded: no count, no log entry, no pulse.
- `clear_i` zeroes the counter, `fatal_o`, `log_overflow_o` and the log.

## Timing
- All outputs are registered. Voted outputs, `mismatch_o` and `faulty_lane_o` appear 1 cycle after the inputs are sampled.
- `err_cnt_o` and `fatal_o` update in that same cycle.
- `log_valid_o` rises 1 cycle after the push. A pop advances the head on the next edge.
- Reset (asynchronous, mid-operation included): every output is 0, the stamp is 0 and the log is empty. The first sample is taken on the first edge after `rst_ni` deasserts.

## Structure
- `alu_tmr_pkg` holds:
  - `tmr_lane_e` (NONE, L1, L2, L3)
  - `tmr_log_entry_t` struct {mask[2:0], stamp}, parameterized via CNT_WIDTH localparam default
  - the `majority3` function.
- Sub-module `alu_tmr_err_fifo` is the generic synchronous FIFO with full/empty flags and a drop-on-full overflow flag. The top holds the vote, classification, counters and stamp.

## Test plan
- All lanes = 0x1234_5678, cmp=1, ready=1, en=1 → next cycle voted=0x1234_5678, mismatch_o=0, err_cnt_o=0, log_valid_o=0.
- Lane 2 result=0x1234_5679 → voted=0x1234_5678, mismatch_o pulse, faulty_lane_o=2, err_cnt_o=1, fatal_o=0, log head mask=3'b010.
- Lane 1 bit0 flipped and lane 3 bit1 flipped → voted equals the lane 2 value, faulty_lane_o=0, fatal_o=1 (sticky after inputs recover), mask=3'b101.
- 5 consecutive single-lane errors, no reads, LOG_DEPTH=4 → 4 entries with increasing stamps, log_overflow_o=1, err_cnt_o=5. Then 4 pops → log_valid_o=0, and a 5th pop is ignored.
- Mismatch and clear_i in the same cycle with err_cnt_o=3 → err_cnt_o=0, no pulse, log empty, fatal/overflow 0.
- Lane 3 ready=0 with en_i=0 → no pulse or log entry, and voted_ready_o=1. Drop `rst_ni` mid-stream → all outputs 0 immediately, without waiting for a clock edge.
